// File: rtl/cache_line_ctrl.sv
// Direct-mapped cache line controller: hit service, dirty writeback, refill and replay.
module cache_line_ctrl #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned TAG_BITS   = 23,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_we,
    input  logic [31:0]           cpu_req_addr,
    input  logic [31:0]           cpu_req_wdata,
    input  logic [3:0]            cpu_req_be,
    output logic                  cpu_resp_valid,
    output logic [31:0]           cpu_resp_rdata,
    output logic                  way_wr_en,
    output logic                  way_refill,
    output logic [ADDR_WIDTH-1:0] way_addr,
    output logic [TAG_BITS-1:0]   way_tag,
    output logic [LINE_WIDTH-1:0] way_wr_data,
    output logic [3:0]            way_word_en,
    output logic [3:0]            way_byte_en,
    input  logic [TAG_BITS-1:0]   way_out_tag,
    input  logic [LINE_WIDTH-1:0] way_rd_data,
    input  logic                  way_hit,
    input  logic                  way_modify,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [31:0]           mem_req_addr,
    output logic [LINE_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [LINE_WIDTH-1:0] mem_resp_rdata
);

    typedef enum logic [3:0] {
        StIdle, StLook0, StLook1, StWbReq, StWbWait, StRfReq, StRfWait, StRfWr, StResp
    } state_e;

    state_e                state_q, state_d;
    logic [31:2]           addr_q, addr_d;
    logic                  we_q, we_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [TAG_BITS-1:0]   victim_tag_q, victim_tag_d;
    // Holds the victim line during writeback, then the refill line.
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [1:0]            req_word;
    logic                  unused_addr_lsbs;

    assign req_index        = addr_q[ADDR_WIDTH+3:4];
    assign req_tag          = addr_q[31:ADDR_WIDTH+4];
    assign req_word         = addr_q[3:2];
    // Byte offset within a word is irrelevant to a word-granular way.
    assign unused_addr_lsbs = ^cpu_req_addr[1:0];
    assign cpu_resp_rdata   = rdata_q;

    // State and latched request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            be_q         <= '0;
            victim_tag_q <= '0;
            line_q       <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            victim_tag_q <= victim_tag_d;
            line_q       <= line_d;
            rdata_q      <= rdata_d;
        end
    end

    // Next-state, register updates and all outputs.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        be_d           = be_q;
        victim_tag_d   = victim_tag_q;
        line_d         = line_q;
        rdata_d        = rdata_q;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        way_wr_en      = 1'b0;
        way_refill     = 1'b0;
        way_addr       = '0;
        way_tag        = '0;
        way_wr_data    = '0;
        way_word_en    = 4'h0;
        way_byte_en    = 4'h0;
        mem_req_valid  = 1'b0;
        mem_req_we     = 1'b0;
        mem_req_addr   = '0;
        mem_req_wdata  = '0;

        if (state_q != StIdle) begin
            way_addr = req_index;
            way_tag  = req_tag;
        end

        case (state_q)
            StIdle: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    addr_d  = cpu_req_addr[31:2];
                    we_d    = cpu_req_we;
                    wdata_d = cpu_req_wdata;
                    be_d    = cpu_req_be;
                    state_d = StLook0;
                end
            end
            StLook0: state_d = StLook1;
            StLook1: begin
                if (way_hit) begin
                    if (we_q) begin
                        way_wr_en   = 1'b1;
                        way_word_en = 4'b0001 << req_word;
                        way_byte_en = be_q;
                        way_wr_data = {(LINE_WIDTH / 32){wdata_q}};
                        rdata_d     = '0;
                    end else begin
                        rdata_d = way_rd_data[{req_word, 5'd0} +: 32];
                    end
                    state_d = StResp;
                end else if (way_modify) begin
                    line_d       = way_rd_data;
                    victim_tag_d = way_out_tag;
                    state_d      = StWbReq;
                end else begin
                    state_d = StRfReq;
                end
            end
            StWbReq: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {victim_tag_q, req_index, 4'h0};
                mem_req_wdata = line_q;
                if (mem_req_ready) state_d = StWbWait;
            end
            StWbWait: if (mem_resp_valid) state_d = StRfReq;
            StRfReq: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, req_index, 4'h0};
                if (mem_req_ready) state_d = StRfWait;
            end
            StRfWait: begin
                if (mem_resp_valid) begin
                    line_d  = mem_resp_rdata;
                    state_d = StRfWr;
                end
            end
            StRfWr: begin
                way_wr_en   = 1'b1;
                way_refill  = 1'b1;
                way_word_en = 4'hF;
                way_byte_en = 4'hF;
                way_wr_data = line_q;
                // Replay the lookup; the freshly refilled line guarantees a hit.
                state_d     = StLook0;
            end
            StResp: begin
                cpu_resp_valid = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Self-checking bench for cache_line_ctrl: way storage model, memory responder,
// reference cache/memory model and a per-cycle compare process.
module tb_cache_line_ctrl;

    localparam int AW = 5;
    localparam int TW = 23;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [31:0]   cpu_req_addr, cpu_req_wdata;
    logic [3:0]    cpu_req_be;
    logic          cpu_resp_valid;
    logic [31:0]   cpu_resp_rdata;
    logic          way_wr_en, way_refill;
    logic [AW-1:0] way_addr;
    logic [TW-1:0] way_tag, way_out_tag;
    logic [127:0]  way_wr_data, way_rd_data;
    logic [3:0]    way_word_en, way_byte_en;
    logic          way_hit, way_modify;
    logic          mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0]   mem_req_addr;
    logic [127:0]  mem_req_wdata;
    logic          mem_resp_valid;
    logic [127:0]  mem_resp_rdata;

    always #5 clk = ~clk;

    cache_line_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata), .cpu_req_be(cpu_req_be),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
        .way_wr_en(way_wr_en), .way_refill(way_refill), .way_addr(way_addr),
        .way_tag(way_tag), .way_wr_data(way_wr_data), .way_word_en(way_word_en),
        .way_byte_en(way_byte_en), .way_out_tag(way_out_tag), .way_rd_data(way_rd_data),
        .way_hit(way_hit), .way_modify(way_modify),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata)
    );

    // ---------------- way storage (the array the controller drives) ----------------
    logic [TW-1:0]  w_tag  [32];
    logic [127:0]   w_data [32];
    logic [31:0]    w_val   = '0;
    logic [31:0]    w_dirty = '0;

    assign way_out_tag = w_tag[way_addr];
    assign way_rd_data = w_data[way_addr];
    assign way_hit     = w_val[way_addr] && (w_tag[way_addr] == way_tag);
    assign way_modify  = w_val[way_addr] && w_dirty[way_addr];

    always @(posedge clk) begin
        if (way_wr_en) begin
            if (way_refill) begin
                w_data[way_addr]  <= way_wr_data;
                w_tag[way_addr]   <= way_tag;
                w_val[way_addr]   <= 1'b1;
                w_dirty[way_addr] <= 1'b0;
            end else begin
                for (int w = 0; w < 4; w++)
                    for (int b = 0; b < 4; b++)
                        if (way_word_en[w] && way_byte_en[b])
                            w_data[way_addr][32*w+8*b +: 8] <= way_wr_data[32*w+8*b +: 8];
                w_dirty[way_addr] <= 1'b1;
            end
        end
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected at cycle %0d", name, cyc);
    endtask

    function automatic logic [127:0] init_line(input logic [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[32*i +: 32] = a ^ (32'h5A5A_0000 | i);
        if (a == 32'h100) l[63:32] = 32'hDEADBEEF;
        return l;
    endfunction

    // ---------------- memory responder ----------------
    logic [127:0] mem [logic [31:0]];
    int           hold_cnt = 0;
    int           pend_cnt = 0;
    int           n_hs     = 0;
    logic         pend_we;
    logic [31:0]  pend_addr;
    logic [31:0]  last_wb_addr = '0, last_rf_addr = '0;
    logic [127:0] last_wb_data = '0;

    function automatic logic [127:0] mem_get(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_line(a);
    endfunction

    initial begin
        logic         hs, hs_we;
        logic [31:0]  hs_addr;
        logic [127:0] hs_wdata;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        forever begin
            @(negedge clk);
            hs       = rst_n && mem_req_valid && mem_req_ready;
            hs_we    = mem_req_we;
            hs_addr  = mem_req_addr;
            hs_wdata = mem_req_wdata;
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
            mem_resp_rdata = '0;
            if (hs) begin
                n_hs++;
                if (hs_we) begin
                    mem[hs_addr] = hs_wdata;
                    last_wb_addr = hs_addr;
                    last_wb_data = hs_wdata;
                end else begin
                    last_rf_addr = hs_addr;
                end
                pend_cnt  = 3;
                pend_we   = hs_we;
                pend_addr = hs_addr;
            end else if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = pend_we ? 128'h0 : mem_get(pend_addr);
                end
            end
            if (hold_cnt > 0 && mem_req_valid) begin
                mem_req_ready = 1'b0;
                hold_cnt--;
            end else begin
                mem_req_ready = 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } mem_op_t;
    typedef struct {
        logic         refill;
        logic [3:0]   word_en;
        logic [3:0]   byte_en;
        logic [127:0] data;
        logic [4:0]   idx;
    } wr_op_t;

    mem_op_t      exp_mem [$];
    wr_op_t       exp_wr  [$];
    logic [127:0] gold [logic [31:0]];  // CPU-visible memory contents
    logic [TW-1:0] m_tag [32];
    bit           m_val   [32];
    bit           m_dirty [32];
    bit           resp_pend = 0;
    bit           exp_hit   = 0;
    logic [31:0]  exp_rdata = '0;
    int           acc_cyc   = 0;
    int           resp_cnt  = 0;
    int           last_lat  = 0;
    int           stall_cnt = 0;

    function automatic logic [127:0] gold_get(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : init_line(a);
    endfunction

    task automatic model_accept(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] be);
        int           idx = int'(a[8:4]);
        int           w   = int'(a[3:2]);
        logic [31:0]  la  = {a[31:4], 4'h0};
        logic [31:0]  va;
        logic [127:0] l;
        logic [3:0]   oh;
        exp_hit = m_val[idx] && (m_tag[idx] == a[31:9]);
        if (!exp_hit) begin
            if (m_val[idx] && m_dirty[idx]) begin
                va = {m_tag[idx], a[8:4], 4'h0};
                exp_mem.push_back('{1'b1, va, gold_get(va)});
            end
            exp_mem.push_back('{1'b0, la, 128'h0});
            exp_wr.push_back('{1'b1, 4'hF, 4'hF, gold_get(la), a[8:4]});
            m_val[idx]   = 1'b1;
            m_tag[idx]   = a[31:9];
            m_dirty[idx] = 1'b0;
        end
        l = gold_get(la);
        if (we) begin
            oh = 4'b0001 << w;
            exp_wr.push_back('{1'b0, oh, be, {4{wd}}, a[8:4]});
            for (int b = 0; b < 4; b++) if (be[b]) l[32*w+8*b +: 8] = wd[8*b +: 8];
            gold[la]     = l;
            m_dirty[idx] = 1'b1;
            exp_rdata    = 32'h0;
        end else begin
            exp_rdata = l[32*w +: 32];
        end
        resp_pend = 1'b1;
        acc_cyc   = cyc;
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        logic         prev_stall = 1'b0;
        logic         prev_we;
        logic [31:0]  prev_addr;
        logic [127:0] prev_wdata;
        mem_op_t      em;
        wr_op_t       ew;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("mem_hold_valid", mem_req_valid, 1);
                    check("mem_hold_we", mem_req_we, prev_we);
                    check("mem_hold_addr", mem_req_addr, prev_addr);
                    check("mem_hold_wdata", mem_req_wdata, prev_wdata);
                end
                prev_stall = mem_req_valid && !mem_req_ready;
                prev_we    = mem_req_we;
                prev_addr  = mem_req_addr;
                prev_wdata = mem_req_wdata;
                if (prev_stall) stall_cnt++;
                if (mem_req_valid && mem_req_ready) begin
                    if (exp_mem.size() == 0) fail_now("mem_req_unexpected");
                    else begin
                        em = exp_mem.pop_front();
                        check("mem_req_we", mem_req_we, em.we);
                        check("mem_req_addr", mem_req_addr, em.addr);
                        if (em.we) check("mem_req_wdata", mem_req_wdata, em.wdata);
                    end
                end
                if (way_wr_en) begin
                    if (exp_wr.size() == 0) fail_now("way_wr_unexpected");
                    else begin
                        ew = exp_wr.pop_front();
                        check("way_refill", way_refill, ew.refill);
                        check("way_word_en", way_word_en, ew.word_en);
                        check("way_byte_en", way_byte_en, ew.byte_en);
                        check("way_wr_data", way_wr_data, ew.data);
                        check("way_addr", way_addr, ew.idx);
                    end
                end
                if (cpu_resp_valid) begin
                    if (!resp_pend) fail_now("resp_unexpected");
                    else begin
                        last_lat = cyc - acc_cyc;
                        check("resp_rdata", cpu_resp_rdata, exp_rdata);
                        if (exp_hit) check("hit_latency", last_lat, 3);
                        resp_pend = 1'b0;
                        resp_cnt++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cpu_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input bit wait_resp);
        int start = resp_cnt;
        int n     = 0;
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = a;
        cpu_req_wdata = wd;
        cpu_req_be    = be;
        @(negedge clk);
        check("req_ready", cpu_req_ready, 1);
        model_accept(we, a, wd, be);
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_wdata = '0;
        cpu_req_be    = '0;
        if (wait_resp) begin
            while (resp_cnt == start && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (resp_cnt == start) fail_now("resp_timeout");
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {cpu_resp_valid, cpu_resp_rdata, way_wr_en, way_refill, way_addr, way_tag,
                     way_word_en, way_byte_en, mem_req_valid, mem_req_we, mem_req_addr}, 0);
        check({name, "_wdata"}, way_wr_data | mem_req_wdata, 0);
        check({name, "_ready"}, cpu_req_ready, 1);
    endtask

    initial begin
        int n;
        int hs_before;
        rst_n         = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_wdata = '0;
        cpu_req_be    = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: cold miss
        cpu_op(1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b1);
        check("t1_refill_addr", last_rf_addr, 32'h0000_0100);
        check("t1_rdata", cpu_resp_rdata, 32'hDEADBEEF);

        // 2: hit, no memory traffic
        hs_before = n_hs;
        cpu_op(1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b1);
        check("t2_latency", last_lat, 3);
        check("t2_no_mem", n_hs, hs_before);

        // 3: byte store then reload
        cpu_op(1'b1, 32'h0000_0104, 32'h0000_AB00, 4'b0010, 1'b1);
        check("t3_store_rdata", cpu_resp_rdata, 32'h0);
        cpu_op(1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b1);
        check("t3_load", cpu_resp_rdata, 32'hDEADABEF);

        // 4: conflict miss with dirty victim
        cpu_op(1'b0, 32'h0000_0304, 32'h0, 4'h0, 1'b1);
        check("t4_wb_addr", last_wb_addr, 32'h0000_0100);
        check("t4_wb_word1", last_wb_data[63:32], 32'hDEADABEF);
        check("t4_refill_addr", last_rf_addr, 32'h0000_0300);
        check("t4_rdata", cpu_resp_rdata, 32'h5A5A_0301);

        // 5: writeback with memory stalling
        cpu_op(1'b1, 32'h0000_0304, 32'h1234_5678, 4'hF, 1'b1);
        stall_cnt = 0;
        hold_cnt  = 5;
        hs_before = n_hs;
        cpu_op(1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b1);
        check("t5_stall_cycles", stall_cnt, 5);
        check("t5_handshakes", n_hs - hs_before, 2);
        check("t5_wb_addr", last_wb_addr, 32'h0000_0300);
        check("t5_wb_word1", last_wb_data[63:32], 32'h1234_5678);
        check("t5_rdata", cpu_resp_rdata, 32'hDEADABEF);

        // 6: reset while waiting for refill data
        cpu_op(1'b0, 32'h0000_0208, 32'h0, 4'h0, 1'b0);
        n = 0;
        while (!(mem_req_valid && mem_req_ready && !mem_req_we) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("t6_refill_req_timeout");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_mem.delete();
        exp_wr.delete();
        resp_pend = 1'b0;
        @(negedge clk);
        check_idle_outputs("t6_reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t6_stray_no_write", {way_wr_en, mem_req_valid, cpu_resp_valid}, 0);
        end
        cpu_op(1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b1);
        check("t6_after_reset", cpu_resp_rdata, 32'hDEADABEF);
        check("t6_after_reset_lat", last_lat, 3);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
